// File: rtl/cc1200_spi_hub.sv
// cc1200_spi_hub: round-robin SPI master and GPIO synchroniser for NUM_CH CC1200 radios.
//
// One shared shift engine serves all channels. Each transaction asserts CS_n, waits for the
// radio to pull MISO low (CHIP_RDYn), shifts a 16-bit frame in SPI mode 0 while capturing 16
// bits from MISO, holds CS_n for CLK_DIV cycles, then reports the result on the rsp_* outputs.
//
// Ports:
//   sysclk, rstn            clock, asynchronous active-low reset
//   req_valid/req_data      per-channel frame requests (16 bits per channel, MSB first)
//   req_ready               one-cycle grant pulse, frame captured in that cycle
//   rsp_valid/rsp_ch/...    completion pulse with channel, MISO data and timeout flag
//   busy                    engine not idle
//   SCLK/CS_n/MOSI/MISO     per-channel SPI pins
//   gpio_in/gpio_sync       raw radio GPIOs and their 2-FF synchronised copies
//   gpio_irq/gpio_irq_clr   sticky per-channel rising-edge flags, write-1-to-clear
//
// Build option: define CC1200_GPIO_IRQ_EN to build the GPIO edge flags; otherwise gpio_irq
// is tied low and gpio_irq_clr is ignored.

module cc1200_spi_hub #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned GPIO_PER_CH = 4,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned RDY_TIMEOUT = 255
) (
  input  logic                          sysclk,
  input  logic                          rstn,
  input  logic [NUM_CH-1:0]             req_valid,
  input  logic [16*NUM_CH-1:0]          req_data,
  output logic [NUM_CH-1:0]             req_ready,
  output logic                          rsp_valid,
  output logic [2:0]                    rsp_ch,
  output logic [15:0]                   rsp_data,
  output logic                          rsp_timeout,
  output logic                          busy,
  output logic [NUM_CH-1:0]             SCLK,
  output logic [NUM_CH-1:0]             CS_n,
  output logic [NUM_CH-1:0]             MOSI,
  input  logic [NUM_CH-1:0]             MISO,
  input  logic [NUM_CH*GPIO_PER_CH-1:0] gpio_in,
  output logic [NUM_CH*GPIO_PER_CH-1:0] gpio_sync,
  output logic [NUM_CH-1:0]             gpio_irq,
  input  logic [NUM_CH-1:0]             gpio_irq_clr
);

  localparam int unsigned ChW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntMax = (RDY_TIMEOUT > CLK_DIV + 1) ? RDY_TIMEOUT : CLK_DIV + 1;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned GpioW  = NUM_CH * GPIO_PER_CH;

  localparam logic [CntW-1:0] DivLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] DoneLast = CntW'(CLK_DIV);
  localparam logic [CntW-1:0] RdyLast  = CntW'(RDY_TIMEOUT - 1);
  localparam logic [ChW-1:0]  LastInit = ChW'(NUM_CH - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StArb   = 3'd1;
  localparam logic [2:0] StRdy   = 3'd2;
  localparam logic [2:0] StShift = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        half_q, half_d;      // SCLK half-period index within SHIFT
  logic [ChW-1:0]    sel_q, sel_d;
  logic [ChW-1:0]    last_q, last_d;
  logic [15:0]       frame_q, frame_d;
  logic [15:0]       rx_q, rx_d;
  logic              to_q, to_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [2:0]        rsp_ch_q, rsp_ch_d;
  logic [15:0]       rsp_data_q, rsp_data_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [NUM_CH-1:0] sclk_q, sclk_d;
  logic [NUM_CH-1:0] cs_n_q, cs_n_d;
  logic [NUM_CH-1:0] mosi_q, mosi_d;

  logic              gnt_found;
  logic [ChW-1:0]    gnt_idx;
  logic [15:0]       gnt_frame;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    int unsigned cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_frame = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = 32'(last_q) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!gnt_found && req_valid[ChW'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ChW'(cand);
      end
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ChW'(i) == gnt_idx) gnt_frame = req_data[16*i +: 16];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    half_d        = half_q;
    sel_d         = sel_q;
    last_d        = last_q;
    frame_d       = frame_q;
    rx_d          = rx_q;
    to_d          = to_q;
    rsp_valid_d   = 1'b0;
    rsp_ch_d      = rsp_ch_q;
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    req_ready     = '0;

    case (state_q)
      StIdle: begin
        if (|req_valid) state_d = StArb;
      end
      StArb: begin
        // A requester that dropped req_valid before arbitration simply loses its slot.
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          sel_d   = gnt_idx;
          last_d  = gnt_idx;
          frame_d = gnt_frame;
          rx_d    = '0;
          to_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRdy;
        end else begin
          state_d = StIdle;
        end
      end
      StRdy: begin
        if (!MISO[sel_q]) begin
          cnt_d   = '0;
          half_d  = '0;
          state_d = StShift;
        end else if (cnt_q == RdyLast) begin
          cnt_d   = '0;
          to_d    = 1'b1;
          state_d = StHold;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShift: begin
        // First cycle of an odd half-period is the cycle SCLK rises: sample MISO.
        if (half_q[0] && (cnt_q == '0)) rx_d = {rx_q[14:0], MISO[sel_q]};
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (half_q == 5'd31) state_d = StHold;
          else                 half_d  = half_q + 5'd1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == DivLast) begin
          cnt_d         = '0;
          state_d       = StDone;
          rsp_valid_d   = 1'b1;
          rsp_ch_d      = 3'(sel_q);
          rsp_data_d    = to_q ? 16'h0000 : rx_q;
          rsp_timeout_d = to_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        // One response cycle followed by CLK_DIV cycles of CS_n high.
        if (cnt_q == DoneLast) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Pin values are registered from next state so the pads never glitch.
    cs_n_d = '1;
    sclk_d = '0;
    mosi_d = '0;
    if ((state_d == StRdy) || (state_d == StShift) || (state_d == StHold)) begin
      cs_n_d[sel_d] = 1'b0;
    end
    if (state_d == StShift) begin
      sclk_d[sel_d] = half_d[0];
      // ~bit_index == 15 - bit_index: MSB first, advancing on each falling edge.
      mosi_d[sel_d] = frame_d[~half_d[4:1]];
    end
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      half_q        <= '0;
      sel_q         <= '0;
      last_q        <= LastInit;
      frame_q       <= '0;
      rx_q          <= '0;
      to_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_ch_q      <= '0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      sclk_q        <= '0;
      cs_n_q        <= '1;
      mosi_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      half_q        <= half_d;
      sel_q         <= sel_d;
      last_q        <= last_d;
      frame_q       <= frame_d;
      rx_q          <= rx_d;
      to_q          <= to_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_ch_q      <= rsp_ch_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      sclk_q        <= sclk_d;
      cs_n_q        <= cs_n_d;
      mosi_q        <= mosi_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_ch      = rsp_ch_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != StIdle);
  assign SCLK        = sclk_q;
  assign CS_n        = cs_n_q;
  assign MOSI        = mosi_q;

  // GPIO synchroniser: plain two-stage capture of the raw pins.
  logic [GpioW-1:0] sync1_q, sync2_q;

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  assign gpio_sync = sync2_q;

`ifdef CC1200_GPIO_IRQ_EN
  logic [GpioW-1:0]  prev_q;
  logic [NUM_CH-1:0] irq_q, irq_d, edge_hit;

  // A new edge wins over a simultaneous clear so no event is lost.
  always_comb begin
    edge_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      edge_hit[i] = |(sync2_q[i*GPIO_PER_CH +: GPIO_PER_CH] &
                      ~prev_q[i*GPIO_PER_CH +: GPIO_PER_CH]);
    end
    irq_d = (irq_q & ~gpio_irq_clr) | edge_hit;
  end

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= '0;
      irq_q  <= '0;
    end else begin
      prev_q <= sync2_q;
      irq_q  <= irq_d;
    end
  end

  assign gpio_irq = irq_q;
`else
  logic unused_irq_clr;
  assign unused_irq_clr = ^gpio_irq_clr;
  assign gpio_irq       = '0;
`endif

endmodule

// File: tb/tb_cc1200_spi_hub.sv
// tb_cc1200_spi_hub: randomized self-checking bench for cc1200_spi_hub.
// A behavioural CC1200 slave per channel answers frames; expected results are derived from
// the request, the slave pattern and the readiness delay.

module tb_cc1200_spi_hub;

  localparam int unsigned NCh   = 4;
  localparam int unsigned Gpc   = 4;
  localparam int unsigned Div   = 2;
  localparam int unsigned RdyTo = 255;
  localparam int          Never = 100000;

  logic                 sysclk = 1'b0;
  logic                 rstn   = 1'b0;
  logic [NCh-1:0]       req_valid;
  logic [16*NCh-1:0]    req_data;
  logic [NCh-1:0]       req_ready;
  logic                 rsp_valid;
  logic [2:0]           rsp_ch;
  logic [15:0]          rsp_data;
  logic                 rsp_timeout;
  logic                 busy;
  logic [NCh-1:0]       sclk, cs_n, mosi;
  logic [NCh-1:0]       miso;
  logic [NCh*Gpc-1:0]   gpio_in, gpio_sync;
  logic [NCh-1:0]       gpio_irq, gpio_irq_clr;

  always #5 sysclk = ~sysclk;

  cc1200_spi_hub #(
    .NUM_CH      (NCh),
    .GPIO_PER_CH (Gpc),
    .CLK_DIV     (Div),
    .RDY_TIMEOUT (RdyTo)
  ) u_dut (
    .sysclk       (sysclk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_ch       (rsp_ch),
    .rsp_data     (rsp_data),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy),
    .SCLK         (sclk),
    .CS_n         (cs_n),
    .MOSI         (mosi),
    .MISO         (miso),
    .gpio_in      (gpio_in),
    .gpio_sync    (gpio_sync),
    .gpio_irq     (gpio_irq),
    .gpio_irq_clr (gpio_irq_clr)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave configuration and observations, per channel.
  logic [15:0] pat      [NCh];
  int          rdy_dly  [NCh];
  int          cs_fall  [NCh];
  int          rise_1st [NCh];
  int          rises    [NCh];
  int          falls    [NCh];
  int          sclk_hi  [NCh];
  int          cs_cnt   [NCh];
  logic [15:0] mosi_cap [NCh];
  bit          active   [NCh];
  bit          rdy_seen [NCh];
  bit          sclk_prv [NCh];
  int          cyc  = 0;
  int          viol = 0;

  // CC1200 slave model: MISO high until ready, then low, then the pattern MSB first,
  // advancing after every SCLK falling edge. Also records MOSI at every rising edge.
  initial begin
    miso = '1;
    for (int c = 0; c < NCh; c++) begin
      active[c] = 0; sclk_prv[c] = 0; rises[c] = 0; falls[c] = 0; sclk_hi[c] = 0;
      cs_fall[c] = -1; rise_1st[c] = -1; mosi_cap[c] = '0; cs_cnt[c] = 0; rdy_seen[c] = 0;
    end
    forever begin
      @(negedge sysclk);
      cyc++;
      if (rstn && ($countones(~cs_n) > 1)) viol++;
      for (int c = 0; c < NCh; c++) begin
        if (cs_n[c] !== 1'b0) begin
          miso[c]   = 1'b1;
          active[c] = 0;
          if (rstn && (sclk[c] || mosi[c])) viol++;
        end else begin
          if (!active[c]) begin
            active[c] = 1; cs_cnt[c] = 0; falls[c] = 0; rises[c] = 0; sclk_hi[c] = 0;
            mosi_cap[c] = '0; cs_fall[c] = cyc; rise_1st[c] = -1; rdy_seen[c] = 0;
          end else begin
            cs_cnt[c]++;
          end
          if (sclk[c] && !sclk_prv[c]) begin
            rises[c]++;
            mosi_cap[c] = {mosi_cap[c][14:0], mosi[c]};
            if (rise_1st[c] < 0) rise_1st[c] = cyc;
          end
          if (!sclk[c] && sclk_prv[c]) falls[c]++;
          if (sclk[c]) sclk_hi[c]++;
          if (!rdy_seen[c]) begin
            if (cs_cnt[c] >= rdy_dly[c]) begin
              miso[c]     = 1'b0;
              rdy_seen[c] = 1;
            end else begin
              miso[c] = 1'b1;
            end
          end else begin
            miso[c] = (falls[c] < 16) ? pat[c][15-falls[c]] : 1'b0;
          end
        end
        sclk_prv[c] = sclk[c];
      end
    end
  end

  // One request on one channel, checked end to end against the slave's view.
  task automatic run_frame(input int ch, input logic [15:0] frame, input logic [15:0] p,
                           input int dly);
    int g_cyc, r_cyc, exp_lat;
    bit got, to_exp;
    logic [15:0] exp_data;
    pat[ch] = p;
    rdy_dly[ch] = dly;
    req_data[16*ch +: 16] = frame;
    req_valid[ch] = 1'b1;
    got = 0; g_cyc = 0; r_cyc = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge sysclk); #1;
      if (req_ready[ch]) begin got = 1; g_cyc = cyc; end
    end
    check_eq($sformatf("ch%0d_grant", ch), 32'(got), 1);
    @(posedge sysclk); #1;
    req_valid[ch] = 1'b0;
    if (got) begin
      got = 0;
      for (int k = 0; k < 1000 && !got; k++) begin
        @(negedge sysclk); #1;
        if (rsp_valid) begin got = 1; r_cyc = cyc; end
      end
      check_eq($sformatf("ch%0d_rsp_seen", ch), 32'(got), 1);
      to_exp   = (dly >= int'(RdyTo));
      exp_data = to_exp ? 16'h0000 : p;
      exp_lat  = to_exp ? 1 + int'(RdyTo) + int'(Div) : dly + 2 + 33 * int'(Div);
      check_eq($sformatf("ch%0d_rsp_ch", ch), 32'(rsp_ch), 32'(ch));
      check_eq($sformatf("ch%0d_rsp_data", ch), 32'(rsp_data), 32'(exp_data));
      check_eq($sformatf("ch%0d_rsp_timeout", ch), 32'(rsp_timeout), 32'(to_exp));
      check_eq($sformatf("ch%0d_latency", ch), 32'(r_cyc - g_cyc), 32'(exp_lat));
      check_eq($sformatf("ch%0d_cs_fall", ch), 32'(cs_fall[ch]), 32'(g_cyc + 1));
      check_eq($sformatf("ch%0d_cs_high_at_rsp", ch), 32'(cs_n[ch]), 1);
      check_eq($sformatf("ch%0d_rises", ch), 32'(rises[ch]), to_exp ? 0 : 16);
      check_eq($sformatf("ch%0d_sclk_hi", ch), 32'(sclk_hi[ch]), to_exp ? 0 : 16 * Div);
      if (!to_exp) begin
        check_eq($sformatf("ch%0d_mosi", ch), 32'(mosi_cap[ch]), 32'(frame));
        check_eq($sformatf("ch%0d_first_rise", ch), 32'(rise_1st[ch]),
                 32'(g_cyc + 2 + dly + int'(Div)));
      end
      got = 0;
      for (int k = 0; k < 50 && !got; k++) begin
        @(negedge sysclk); #1;
        if (!busy) got = 1;
      end
      check_eq($sformatf("ch%0d_idle", ch), 32'(got), 1);
      check_eq($sformatf("ch%0d_rsp_hold", ch), 32'(rsp_data), 32'(exp_data));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v, old;
    int gi;
    bit got;
    req_valid = '0;
    req_data  = '0;
    gpio_in   = '1;
    gpio_irq_clr = '0;
    for (int c = 0; c < NCh; c++) begin pat[c] = '0; rdy_dly[c] = 0; end

    // Reset values (gpio_in held high to show gpio_sync ignores the pins in reset).
    repeat (3) @(negedge sysclk);
    #1;
    check_eq("rst_cs_n", 32'(cs_n), 32'hF);
    check_eq("rst_sclk", 32'(sclk), 0);
    check_eq("rst_mosi", 32'(mosi), 0);
    check_eq("rst_req_ready", 32'(req_ready), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("rst_rsp_ch", 32'(rsp_ch), 0);
    check_eq("rst_rsp_data", 32'(rsp_data), 0);
    check_eq("rst_rsp_timeout", 32'(rsp_timeout), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_gpio_sync", 32'(gpio_sync), 0);
    check_eq("rst_gpio_irq", 32'(gpio_irq), 0);
    gpio_in = '0;
    @(negedge sysclk); #1;
    rstn = 1'b1;
    repeat (2) @(negedge sysclk);
    #1;

    // Round robin with every channel requesting continuously: 0,1,2,3,0.
    for (int c = 0; c < NCh; c++) begin
      pat[c] = 16'($urandom);
      rdy_dly[c] = int'($urandom_range(0, 3));
      req_data[16*c +: 16] = 16'($urandom);
    end
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      got = 0; gi = -1;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge sysclk); #1;
        if (|req_ready) begin
          got = 1;
          for (int c = 0; c < NCh; c++) if (req_ready[c]) gi = c;
          check_eq($sformatf("rr_onehot%0d", k), $countones(req_ready), 1);
        end
      end
      check_eq($sformatf("rr_grant%0d", k), 32'(gi), 32'(k % NCh));
      @(posedge sysclk); #1;
      if (k == 4) req_valid = '0;
      got = 0;
      for (int w = 0; w < 1000 && !got; w++) begin
        @(negedge sysclk); #1;
        if (rsp_valid) got = 1;
      end
      check_eq($sformatf("rr_rsp_seen%0d", k), 32'(got), 1);
      check_eq($sformatf("rr_rsp_ch%0d", k), 32'(rsp_ch), 32'(k % NCh));
      check_eq($sformatf("rr_rsp_data%0d", k), 32'(rsp_data), 32'(pat[k % NCh]));
    end
    got = 0;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge sysclk); #1;
      if (!busy) got = 1;
    end
    check_eq("rr_idle", 32'(got), 1);

    // Directed frames: nominal, CHIP_RDYn timeout, late readiness.
    run_frame(0, 16'h2F5A, 16'hA5C3, 0);
    run_frame(1, 16'($urandom), 16'($urandom), Never);
    check_eq("to_cs1_high", 32'(cs_n[1]), 1);
    run_frame(2, 16'($urandom), 16'($urandom), 10);

    // Reset in the middle of SHIFT.
    pat[3] = 16'($urandom);
    rdy_dly[3] = 0;
    req_data[48 +: 16] = 16'($urandom);
    req_valid[3] = 1'b1;
    got = 0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge sysclk); #1;
      if (req_ready[3]) got = 1;
    end
    check_eq("mid_grant", 32'(got), 1);
    @(posedge sysclk); #1;
    req_valid[3] = 1'b0;
    got = 0;
    for (int w = 0; w < 50 && !got; w++) begin
      @(negedge sysclk); #1;
      if (sclk[3]) got = 1;
    end
    check_eq("mid_sclk_seen", 32'(got), 1);
    #2 rstn = 1'b0;
    #1;
    check_eq("mid_rst_cs_n", 32'(cs_n), 32'hF);
    check_eq("mid_rst_sclk", 32'(sclk), 0);
    check_eq("mid_rst_mosi", 32'(mosi), 0);
    check_eq("mid_rst_busy", 32'(busy), 0);
    @(negedge sysclk); #1;
    rstn = 1'b1;
    repeat (2) @(negedge sysclk);
    #1;
    run_frame(3, 16'($urandom), 16'($urandom), int'($urandom_range(0, 5)));

    // Randomized traffic.
    for (int k = 0; k < 10; k++) begin
      run_frame(int'($urandom_range(0, NCh - 1)), 16'($urandom), 16'($urandom),
                ($urandom_range(0, 5) == 0) ? Never : int'($urandom_range(0, 20)));
    end
    check_eq("idle_channels_quiet", 32'(viol), 0);

    // GPIO synchroniser: two-cycle latency.
    for (int k = 0; k < 3; k++) begin
      v = 16'($urandom);
      @(negedge sysclk);
      old = gpio_sync;
      gpio_in = v;
      @(negedge sysclk);
      check_eq($sformatf("sync_lat1_%0d", k), 32'(gpio_sync), 32'(old));
      @(negedge sysclk);
      check_eq($sformatf("sync_lat2_%0d", k), 32'(gpio_sync), 32'(v));
    end

    @(negedge sysclk);
    gpio_in = '0;
    gpio_irq_clr = '1;
    repeat (4) @(negedge sysclk);
    gpio_irq_clr = '0;
    @(negedge sysclk);
    check_eq("irq_cleared", 32'(gpio_irq), 0);
    gpio_in[5] = 1'b1;
    repeat (2) @(negedge sysclk);
`ifdef CC1200_GPIO_IRQ_EN
    check_eq("irq_not_yet", 32'(gpio_irq), 0);
    @(negedge sysclk);
    check_eq("irq_set", 32'(gpio_irq), 32'h2);
    repeat (3) @(negedge sysclk);
    check_eq("irq_sticky", 32'(gpio_irq), 32'h2);
    gpio_irq_clr[1] = 1'b1;
    @(negedge sysclk);
    gpio_irq_clr[1] = 1'b0;
    check_eq("irq_clr", 32'(gpio_irq), 0);
    gpio_in[5] = 1'b0;
    repeat (4) @(negedge sysclk);
    gpio_irq_clr[1] = 1'b1;
    gpio_in[5] = 1'b1;
    repeat (3) @(negedge sysclk);
    check_eq("irq_set_beats_clr", 32'(gpio_irq), 32'h2);
    @(negedge sysclk);
    check_eq("irq_clr_after", 32'(gpio_irq), 0);
    gpio_irq_clr[1] = 1'b0;
`else
    @(negedge sysclk);
    check_eq("irq_off_edge", 32'(gpio_irq), 0);
    gpio_irq_clr[1] = 1'b1;
    @(negedge sysclk);
    gpio_irq_clr[1] = 1'b0;
    check_eq("irq_off_clr", 32'(gpio_irq), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
